// File: rtl/hash_light_pkg.sv
// Shared types and constants for the light-hash message driver.
//   drv_state_t : driver FSM states
//   BLOCK_BYTES : bytes per hash block
//   PAD_BYTE    : first padding byte after the final message byte
//   LEN_W       : width of the message length block
//   IDX_W       : width of the byte-lane index inside a block
package hash_light_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    START,
    WAIT,
    PAD,
    LEN,
    OUT
  } drv_state_t;

  localparam int         BLOCK_BYTES = 4;
  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam int         LEN_W       = 32;
  localparam int         IDX_W       = $clog2(BLOCK_BYTES);

endpackage

// File: rtl/hash_msg_driver_if.sv
// Bundle of every handshake/bus signal around the message driver.
//   in_*   : byte stream from the system source
//   core_* : start/done interface to the hash core
//   d_*    : final digest output
//   err    : core timeout pulse
// Handshake rules: a byte transfers on a rising clk edge where
// in_valid && in_ready; a digest transfers where d_valid && d_ready, and
// d_valid/d_out stay stable until that edge. core_start is a one-cycle pulse
// and core_done a one-cycle pulse with core_d valid in the same cycle; no
// second core_start is issued before core_done of the previous one.
// Modport master is the driver's view, slave is the environment's view.
interface hash_msg_driver_if;

  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready;
  logic        core_start;
  logic [31:0] core_m;
  logic [31:0] core_iv;
  logic [31:0] core_d;
  logic        core_done;
  logic [31:0] d_out;
  logic        d_valid;
  logic        d_ready;
  logic        err;

  modport master (
    input  in_valid, in_byte, in_last, core_d, core_done, d_ready,
    output in_ready, core_start, core_m, core_iv, d_out, d_valid, err
  );

  modport slave (
    output in_valid, in_byte, in_last, core_d, core_done, d_ready,
    input  in_ready, core_start, core_m, core_iv, d_out, d_valid, err
  );

endinterface

// File: rtl/hash_block_packer.sv
// Packs message bytes into a 4-byte block.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : return the lane index to 0 (abort)
//   accept    : a byte is transferred this cycle
//   data      : the byte being transferred
//   last      : the byte is the final message byte
//   blk       : block accumulated so far (held by the parent)
//   blk_next  : blk with data inserted in the current lane, 0x80 padding
//               after it when last, zeros in every higher lane
//   blk_done  : the block is ready to send (full or final byte)
//   pad_set   : the final byte filled the block, so a pure padding block
//               must follow
module hash_block_packer
  import hash_light_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        last,
  input  logic [31:0] blk,
  output logic [31:0] blk_next,
  output logic        blk_done,
  output logic        pad_set
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
    end else if (accept) begin
      // A final byte always ends the block, so the next message restarts at lane 0.
      idx <= last ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    blk_next = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (k < int'(idx)) begin
        blk_next[8*k +: 8] = blk[8*k +: 8];
      end else if (k == int'(idx)) begin
        blk_next[8*k +: 8] = data;
      end else if (last && (k == int'(idx) + 1)) begin
        blk_next[8*k +: 8] = PAD_BYTE;
      end
    end
  end

  assign blk_done = accept && (last || (idx == LAST_IDX));
  assign pad_set  = accept && last && (idx == LAST_IDX);

endmodule

// File: rtl/hash_msg_driver.sv
// Initiator side of the light-hash core. Packs a byte stream into 4-byte
// blocks, appends 0x80/zero padding and a 32-bit byte-length block, runs
// the core once per block chaining each digest as the next IV, and offers
// the final digest on a valid/ready output.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : hash_msg_driver_if.master (byte input, core start/done,
//               digest output, err)
//   fsm_state : current FSM state, for observation
module hash_msg_driver
  import hash_light_pkg::*;
#(
  parameter logic [31:0] IV_INIT  = 32'h0123_4567,
  parameter int          WAIT_MAX = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  hash_msg_driver_if.master         bus,
  output drv_state_t                fsm_state
);

  localparam int            TW     = $clog2(WAIT_MAX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(WAIT_MAX - 1);

  drv_state_t       state;
  drv_state_t       state_next;
  logic [31:0]      core_m;
  logic [31:0]      core_iv;
  logic [31:0]      chain;
  logic [LEN_W-1:0] len_cnt;
  logic             pad_flag;
  logic             len_flag;
  logic             msg_end;
  logic [TW-1:0]    timer;

  logic             accept;
  logic             timeout;
  logic             blk_done;
  logic             pad_set;
  logic [31:0]      blk_next;

  assign accept = bus.in_valid && (state == COLLECT);

  // Timer counts completed WAIT cycles; the abort fires in the WAIT_MAX-th
  // WAIT cycle, i.e. WAIT_MAX cycles after the core_start cycle.
  assign timeout = (state == WAIT) && !bus.core_done && (timer == T_LAST);

  hash_block_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timeout),
    .accept   (accept),
    .data     (bus.in_byte),
    .last     (bus.in_last),
    .blk      (core_m),
    .blk_next (blk_next),
    .blk_done (blk_done),
    .pad_set  (pad_set)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    bus.in_ready   = 1'b0;
    bus.core_start = 1'b0;
    bus.d_valid    = 1'b0;
    bus.err        = timeout;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (blk_done) state_next = START;
      end
      START: begin
        bus.core_start = 1'b1;
        state_next     = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          if (pad_flag)      state_next = PAD;
          else if (len_flag) state_next = LEN;
          else if (msg_end)  state_next = OUT;
          else               state_next = COLLECT;
        end else if (timeout) begin
          state_next = COLLECT;
        end
      end
      PAD:     state_next = START;
      LEN:     state_next = START;
      OUT: begin
        bus.d_valid = 1'b1;
        if (bus.d_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // A timeout is a full clear, identical to reset for every register.
  always_ff @(posedge clk) begin
    if (rst || timeout) begin
      core_m   <= '0;
      core_iv  <= IV_INIT;
      chain    <= '0;
      len_cnt  <= '0;
      pad_flag <= 1'b0;
      len_flag <= 1'b0;
      msg_end  <= 1'b0;
      timer    <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            core_m  <= blk_next;
            len_cnt <= len_cnt + 1'b1;
            if (bus.in_last) begin
              len_flag <= 1'b1;
              msg_end  <= 1'b1;
              pad_flag <= pad_set;
            end
          end
        end
        START: timer <= '0;
        WAIT: begin
          if (bus.core_done) begin
            chain   <= bus.core_d;
            core_iv <= bus.core_d;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PAD: begin
          core_m   <= {24'h0, PAD_BYTE};
          pad_flag <= 1'b0;
        end
        LEN: begin
          core_m   <= len_cnt;
          len_flag <= 1'b0;
        end
        OUT: begin
          if (bus.d_ready) begin
            core_iv <= IV_INIT;
            len_cnt <= '0;
            msg_end <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // chain only moves on core_done, so d_out is stable for the whole OUT state.
  assign bus.d_out   = chain;
  assign bus.core_m  = core_m;
  assign bus.core_iv = core_iv;
  assign fsm_state   = state;

endmodule

// File: tb/tb_hash_msg_driver.sv
// Directed-vector bench for hash_msg_driver with a behavioural hash core
// (27-cycle latency, digest = m ^ iv ^ 32'hA5A5_A5A5).
module tb_hash_msg_driver;
  import hash_light_pkg::*;

  localparam logic [31:0] IV       = 32'h0123_4567;
  localparam logic [31:0] K        = 32'hA5A5_A5A5;
  localparam int          WAIT_MAX = 64;
  localparam int          CORE_LAT = 27;

  logic       clk = 1'b0;
  logic       rst;
  drv_state_t fsm_state;
  int         errors = 0;
  int         checks = 0;

  hash_msg_driver_if bus ();

  hash_msg_driver #(.IV_INIT(IV), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural core + start log ----------------
  logic [31:0] obs_m_q[$];
  logic [31:0] obs_iv_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_iv_q[$];
  bit          core_dead = 1'b0;
  bit          busy      = 1'b0;
  bit          viol      = 1'b0;
  int          cnt       = 0;
  logic [31:0] lat_m;
  logic [31:0] lat_iv;

  always @(negedge clk) begin
    if (rst) begin
      busy          = 1'b0;
      bus.core_done = 1'b0;
      bus.core_d    = '0;
    end else if (bus.core_done) begin
      bus.core_done = 1'b0;
      busy          = 1'b0;
    end else if (busy) begin
      if (bus.core_m !== lat_m || bus.core_iv !== lat_iv || bus.core_start) viol = 1'b1;
      cnt++;
      if (cnt == CORE_LAT) begin
        bus.core_d    = lat_m ^ lat_iv ^ K;
        bus.core_done = 1'b1;
      end
    end else if (bus.core_start) begin
      obs_m_q.push_back(bus.core_m);
      obs_iv_q.push_back(bus.core_iv);
      if (!core_dead) begin
        busy   = 1'b1;
        cnt    = 0;
        lat_m  = bus.core_m;
        lat_iv = bus.core_iv;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit last, output bit ok);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.in_ready === 1'b1);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_dvalid(input int budget, output bit ok);
    int n = 0;
    while (bus.d_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.d_valid === 1'b1);
  endtask

  task automatic accept_digest;
    bus.d_ready = 1'b1;
    @(negedge clk);
    bus.d_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    bus.in_last  = 1'b0;
    bus.d_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got=%0b exp=0", bus.core_start); end
    checks++; if (bus.core_m !== 32'h0) begin errors++; $display("FAIL reset_core_m got=%h exp=0", bus.core_m); end
    checks++; if (bus.core_iv !== IV) begin errors++; $display("FAIL reset_core_iv got=%h exp=%h", bus.core_iv, IV); end
    checks++; if (bus.d_out !== 32'h0) begin errors++; $display("FAIL reset_d_out got=%h exp=0", bus.d_out); end
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got=%0b exp=0", bus.d_valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    checks++; if (fsm_state !== COLLECT) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, COLLECT); end
  endtask

  task automatic test_one_byte(input string tag);
    bit ok;
    logic [31:0] d1, d2, act;
    obs_m_q.delete(); obs_iv_q.delete();
    exp_q    = '{32'h0000_80AB, 32'h0000_0001};
    d1       = 32'h0000_80AB ^ IV ^ K;
    d2       = 32'h0000_0001 ^ d1 ^ K;
    exp_iv_q = '{IV, d1};
    send_byte(8'hAB, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept in_ready timeout", tag); end
    wait_dvalid(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_dvalid_timeout got=0 exp=1", tag); end
    checks++; if (bus.d_out !== d2) begin errors++; $display("FAIL %s_d_out got=%h exp=%h", tag, bus.d_out, d2); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s_in_ready_out got=%0b exp=0", tag, bus.in_ready); end
    checks++; if (obs_m_q.size() != 2) begin errors++; $display("FAIL %s_starts got=%0d exp=2", tag, obs_m_q.size()); end
    for (int i = 0; i < 2; i++) begin
      act = (i < obs_m_q.size()) ? obs_m_q[i] : 32'hx;
      checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL %s_m%0d got=%h exp=%h", tag, i, act, exp_q[i]); end
      act = (i < obs_iv_q.size()) ? obs_iv_q[i] : 32'hx;
      checks++; if (act !== exp_iv_q[i]) begin errors++; $display("FAIL %s_iv%0d got=%h exp=%h", tag, i, act, exp_iv_q[i]); end
    end
    accept_digest();
    checks++; if (bus.d_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_after_accept d_valid=%0b in_ready=%0b exp 0/1", tag, bus.d_valid, bus.in_ready);
    end
  endtask

  // Sends bytes, checks the block/IV sequence and the final digest.
  task automatic test_blocks(input string tag, input logic [7:0] bytes[$], input logic [31:0] blocks[$]);
    bit ok, all_ok;
    logic [31:0] iv, act;
    int pulses;
    obs_m_q.delete(); obs_iv_q.delete();
    exp_q = blocks;
    exp_iv_q.delete();
    iv = IV;
    foreach (blocks[i]) begin
      exp_iv_q.push_back(iv);
      iv = blocks[i] ^ iv ^ K;
    end
    all_ok = 1'b1;
    foreach (bytes[i]) begin
      send_byte(bytes[i], i == bytes.size() - 1, ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL %s_accept in_ready timeout", tag); end
    wait_dvalid(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_dvalid_timeout got=0 exp=1", tag); end
    checks++; if (bus.d_out !== iv) begin errors++; $display("FAIL %s_d_out got=%h exp=%h", tag, bus.d_out, iv); end
    checks++; if (obs_m_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_starts got=%0d exp=%0d", tag, obs_m_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      act = (i < obs_m_q.size()) ? obs_m_q[i] : 32'hx;
      checks++; if (act !== exp_q[i]) begin errors++; $display("FAIL %s_m%0d got=%h exp=%h", tag, i, act, exp_q[i]); end
      act = (i < obs_iv_q.size()) ? obs_iv_q[i] : 32'hx;
      checks++; if (act !== exp_iv_q[i]) begin errors++; $display("FAIL %s_iv%0d got=%h exp=%h", tag, i, act, exp_iv_q[i]); end
    end
    accept_digest();
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.d_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0 || obs_m_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_single_digest extra_dvalid=%0d starts=%0d exp 0/%0d", tag, pulses, obs_m_q.size(), exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [31:0] d1, d2;
    d1 = 32'h0000_805A ^ IV ^ K;
    d2 = 32'h0000_0001 ^ d1 ^ K;
    send_byte(8'h5A, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept in_ready timeout"); end
    wait_dvalid(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_dvalid_timeout got=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (bus.d_valid !== 1'b1 || bus.d_out !== d2 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d d_valid=%0b d_out=%h in_ready=%0b exp 1/%h/0", i, bus.d_valid, bus.d_out, bus.in_ready, d2);
      end
    end
    accept_digest();
    test_one_byte("after_bp");
  endtask

  task automatic test_timeout;
    bit ok;
    int n = 0;
    int k = 0;
    core_dead = 1'b1;
    send_byte(8'h11, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_accept in_ready timeout"); end
    while (bus.core_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL to_start got=0 exp=1"); end
    while (bus.err !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != WAIT_MAX) begin errors++; $display("FAIL to_err_delay got=%0d exp=%0d", k, WAIT_MAX); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL to_err_width got=%0b exp=0", bus.err); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL to_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL to_d_valid got=%0b exp=0", bus.d_valid); end
    checks++; if (bus.core_iv !== IV || bus.core_m !== 32'h0) begin
      errors++; $display("FAIL to_cleared core_iv=%h core_m=%h exp %h/0", bus.core_iv, bus.core_m, IV);
    end
    core_dead = 1'b0;
    test_one_byte("after_to");
  endtask

  task automatic test_reset_mid;
    bit ok;
    send_byte(8'h33, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_accept in_ready timeout"); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.core_start !== 1'b0 || bus.err !== 1'b0 || bus.d_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl in_ready=%0b start=%0b err=%0b d_valid=%0b exp 1/0/0/0", bus.in_ready, bus.core_start, bus.err, bus.d_valid);
    end
    checks++; if (bus.core_m !== 32'h0 || bus.core_iv !== IV || bus.d_out !== 32'h0) begin
      errors++; $display("FAIL rstmid_data core_m=%h core_iv=%h d_out=%h exp 0/%h/0", bus.core_m, bus.core_iv, bus.d_out, IV);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_one_byte("after_rst");
  endtask

  initial begin
    test_reset();
    test_one_byte("one_byte");
    test_blocks("four_bytes", '{8'h01, 8'h02, 8'h03, 8'h04},
                '{32'h0403_0201, 32'h0000_0080, 32'h0000_0004});
    test_blocks("five_bytes", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05},
                '{32'h0403_0201, 32'h0000_8005, 32'h0000_0005});
    test_backpressure();
    test_timeout();
    test_reset_mid();
    checks++; if (viol) begin errors++; $display("FAIL core_if_stability got=1 exp=0"); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
